// File: rtl/stereo_pkg.sv
// -----------------------------------------------------------------------------
// stereo_pkg
// Shared constants for the stereo census / disparity pipeline.
//   DEF_*      : default geometry used by census_window and its line buffers
//   CENSUS_W   : census vector width, shared with the disparity minimiser
//   census_t   : census vector type (lham/rham operands downstream)
//   clog2_min1 : address/counter width helper that never returns zero
// -----------------------------------------------------------------------------
package stereo_pkg;
   localparam int DEF_PIXEL_WIDTH  = 8;
   localparam int DEF_LINE_WIDTH   = 16;
   localparam int DEF_NUM_LINES    = 3;
   localparam int DEF_HAMMING_SIZE = DEF_NUM_LINES * DEF_NUM_LINES - 2;
   localparam int CENSUS_W         = DEF_HAMMING_SIZE + 1;

   typedef logic [CENSUS_W-1:0] census_t;

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction
endpackage

// File: rtl/census_linebuf.sv
// -----------------------------------------------------------------------------
// census_linebuf
// One image line of pixel storage, indexed by column. The read port is
// combinational so the old contents at i_addr are seen before the write
// at the same address lands on the clock edge (read-before-write).
//   i_clk   : clock
//   i_we    : write enable (one write per accepted pixel)
//   i_addr  : column address, shared by read and write
//   i_wdata : data written at i_addr
//   o_rdata : current contents at i_addr
// -----------------------------------------------------------------------------
module census_linebuf
   import stereo_pkg::*;
#(
   parameter int DATA_W = DEF_PIXEL_WIDTH,
   parameter int DEPTH  = DEF_LINE_WIDTH,
   parameter int ADDR_W = clog2_min1(DEF_LINE_WIDTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);
   // Contents are never cleared; stale data is masked by the window valid logic.
   logic [DATA_W-1:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end
endmodule

// File: rtl/census_window.sv
// -----------------------------------------------------------------------------
// census_window
// Streaming NUM_LINES x NUM_LINES census transform over a raster pixel stream.
//   clk       : clock, rising edge
//   reset     : synchronous, active-low; overrides pix_valid/sof
//   pix_in    : raster-order pixel
//   pix_valid : pix_in accepted this edge (no backpressure)
//   sof       : start of frame, qualified by pix_valid; pixel is (0,0)
//   ham_out   : census vector, bit HAMMING_SIZE = top-left neighbour
//   ham_valid : one-cycle pulse, one edge after the pixel that completes a window
// -----------------------------------------------------------------------------
module census_window
   import stereo_pkg::*;
#(
   parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
   parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
   parameter int NUM_LINES    = DEF_NUM_LINES,
   parameter int HAMMING_SIZE = NUM_LINES * NUM_LINES - 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PIXEL_WIDTH-1:0] pix_in,
   input  logic                   pix_valid,
   input  logic                   sof,
   output logic [HAMMING_SIZE:0]  ham_out,
   output logic                   ham_valid
);
   localparam int COL_W = clog2_min1(LINE_WIDTH);
   localparam int ROW_W = clog2_min1(NUM_LINES);
   localparam int CTR   = (NUM_LINES - 1) / 2;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_MIN  = COL_W'(NUM_LINES - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_LINES - 1);

   logic [COL_W-1:0]       r_col, w_col_cur;
   logic [ROW_W-1:0]       r_row, w_row_cur;
   logic [PIXEL_WIDTH-1:0] r_win     [NUM_LINES][NUM_LINES];
   logic [PIXEL_WIDTH-1:0] w_win_nxt [NUM_LINES][NUM_LINES];
   logic [PIXEL_WIDTH-1:0] w_lb_rd   [NUM_LINES-1];
   logic [HAMMING_SIZE:0]  r_ham, w_census;
   logic                   r_ham_vld, w_full;

   // sof relabels the incoming pixel as (0,0) before anything else uses the counts.
   assign w_col_cur = sof ? '0 : r_col;
   assign w_row_cur = sof ? '0 : r_row;
   // Row saturates at ROW_LAST, so equality means "enough lines in this frame".
   assign w_full    = (w_row_cur == ROW_LAST) && (w_col_cur >= COL_MIN);

   // Buffer 0 holds the previous line, buffer k the line k+1 above; each
   // buffer passes its displaced pixel down to the next-older buffer.
   for (genvar k = 0; k < NUM_LINES - 1; k++) begin : g_lb
      logic [PIXEL_WIDTH-1:0] w_wdata;
      if (k == 0) begin : g_head
         assign w_wdata = pix_in;
      end else begin : g_tail
         assign w_wdata = w_lb_rd[k-1];
      end
      census_linebuf #(
         .DATA_W (PIXEL_WIDTH),
         .DEPTH  (LINE_WIDTH),
         .ADDR_W (COL_W)
      ) u_lb (
         .i_clk   (clk),
         .i_we    (pix_valid & reset),
         .i_addr  (w_col_cur),
         .i_wdata (w_wdata),
         .o_rdata (w_lb_rd[k])
      );
   end

   // Window after this pixel: shift left, new right column oldest line on top.
   always_comb begin
      for (int r = 0; r < NUM_LINES; r++) begin
         for (int c = 0; c < NUM_LINES - 1; c++) w_win_nxt[r][c] = r_win[r][c+1];
      end
      for (int r = 0; r < NUM_LINES - 1; r++) w_win_nxt[r][NUM_LINES-1] = w_lb_rd[NUM_LINES-2-r];
      w_win_nxt[NUM_LINES-1][NUM_LINES-1] = pix_in;
   end

   // Census over the post-shift window so the vector registers one edge after acceptance.
   always_comb begin
      int b;
      w_census = '0;
      b        = HAMMING_SIZE;
      for (int r = 0; r < NUM_LINES; r++) begin
         for (int c = 0; c < NUM_LINES; c++) begin
            if (!(r == CTR && c == CTR)) begin
               w_census[b] = (w_win_nxt[r][c] < w_win_nxt[CTR][CTR]);
               b           = b - 1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_col     <= '0;
         r_row     <= '0;
         r_ham     <= '0;
         r_ham_vld <= 1'b0;
         for (int r = 0; r < NUM_LINES; r++)
            for (int c = 0; c < NUM_LINES; c++) r_win[r][c] <= '0;
      end else begin
         r_ham_vld <= 1'b0;
         if (pix_valid) begin
            r_win <= w_win_nxt;
            if (w_full) begin
               r_ham     <= w_census;
               r_ham_vld <= 1'b1;
            end
            if (w_col_cur == COL_LAST) begin
               r_col <= '0;
               r_row <= (w_row_cur == ROW_LAST) ? w_row_cur : w_row_cur + 1'b1;
            end else begin
               r_col <= w_col_cur + 1'b1;
               r_row <= w_row_cur;
            end
         end
      end
   end

   assign ham_out   = r_ham;
   assign ham_valid = r_ham_vld;
endmodule

// File: tb/tb_census_window.sv
module tb_census_window;
   localparam int LW   = 16;
   localparam int MAXR = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] pix_in = '0;
   logic       pix_valid = 1'b0;
   logic       sof = 1'b0;
   logic [7:0] ham_out;
   logic       ham_valid;

   census_window dut (
      .clk       (clk),
      .reset     (reset),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .sof       (sof),
      .ham_out   (ham_out),
      .ham_valid (ham_valid)
   );

   always #5 clk = ~clk;

   // Reference model: the frame as a 2-D image plus current frame coordinates.
   logic [7:0] img  [0:MAXR-1][0:LW-1];
   logic [7:0] gotc [0:MAXR-1][0:LW-1];
   int         mcol = 0, mrow = 0;
   logic [7:0] last_ham = '0;
   logic       exp_v, obs_v;
   logic [7:0] exp_h, obs_h;
   int         checks = 0, errors = 0, pulses = 0;
   logic [7:0] seq [$];

   // Census of the 3x3 window whose bottom-right pixel is (r,c), centre (r-1,c-1).
   function automatic logic [7:0] census(input int r, input int c);
      logic [7:0] v;
      int         b;
      v = '0;
      b = 7;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            if (!(i == 1 && j == 1)) begin
               v[b] = (img[r-2+i][c-2+j] < img[r-1][c-1]);
               b--;
            end
      return v;
   endfunction

   function automatic logic [7:0] pat(input int kind, input int r, input int c);
      case (kind)
         0:       return 8'h80;
         1:       return (r == 1) ? 8'h10 : 8'h80;
         2:       return (r == 2 && c == 2) ? 8'hFF : 8'h00;
         3:       return 8'((r * LW + c) * 7);
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic model_reset();
      mcol = 0; mrow = 0; last_ham = '0;
   endtask

   // Drive one accepted pixel, predict, and capture the registered outputs.
   task automatic push(input logic [7:0] p, input logic s);
      pix_in = p; sof = s; pix_valid = 1'b1;
      if (s) begin mcol = 0; mrow = 0; end
      img[mrow][mcol] = p;
      exp_v = (mrow >= 2 && mcol >= 2);
      exp_h = last_ham;
      if (exp_v) exp_h = census(mrow, mcol);
      @(posedge clk); #1;
      pix_valid = 1'b0; sof = 1'b0;
      obs_v = ham_valid; obs_h = ham_out;
      if (exp_v) begin
         last_ham = exp_h;
         pulses++;
         gotc[mrow-1][mcol-1] = obs_h;
         seq.push_back(obs_h);
      end
      mcol++;
      if (mcol == LW) begin
         mcol = 0;
         if (mrow < MAXR - 1) mrow++;
      end
   endtask

   // Idle cycle: junk on pix_in/sof must be ignored, output must hold.
   task automatic gap();
      pix_in = 8'($urandom); sof = 1'($urandom); pix_valid = 1'b0;
      @(posedge clk); #1;
      sof = 1'b0;
      exp_v = 1'b0; exp_h = last_ham;
      obs_v = ham_valid; obs_h = ham_out;
   endtask

   task automatic test_reset();
      reset = 1'b0; pix_valid = 1'b1; sof = 1'b1; pix_in = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ham_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ham_valid); end
      checks++;
      if (ham_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", ham_out); end
      reset = 1'b1; pix_valid = 1'b0; sof = 1'b0;
      model_reset();
   endtask

   task automatic test_images();
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < MAXR; r++) for (int c = 0; c < LW; c++) gotc[r][c] = 8'h5A;
         pulses = 0;
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < LW; c++) begin
               push(pat(k, r, c), r == 0 && c == 0);
               checks++;
               if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
                  errors++;
                  $display("FAIL image%0d r%0d c%0d got v=%b h=%h exp v=%b h=%h", k, r, c, obs_v, obs_h, exp_v, exp_h);
               end
            end
         checks++;
         if (pulses != 42) begin errors++; $display("FAIL image%0d_pulses got %0d exp 42", k, pulses); end
         if (k == 0) begin
            checks++;
            if (gotc[2][8] !== 8'h00) begin errors++; $display("FAIL flat_vec got %h exp 00", gotc[2][8]); end
         end else if (k == 1) begin
            checks++;
            if (gotc[2][5] !== 8'hE0) begin errors++; $display("FAIL line1_c2 got %h exp E0", gotc[2][5]); end
            checks++;
            if (gotc[3][5] !== 8'h00) begin errors++; $display("FAIL line1_c3 got %h exp 00", gotc[3][5]); end
            checks++;
            if (gotc[1][5] !== 8'h00) begin errors++; $display("FAIL line1_c1 got %h exp 00", gotc[1][5]); end
         end else begin
            checks++;
            if (gotc[2][2] !== 8'hFF) begin errors++; $display("FAIL spike_c22 got %h exp FF", gotc[2][2]); end
            checks++;
            if (gotc[1][1] !== 8'h00) begin errors++; $display("FAIL spike_c11 got %h exp 00", gotc[1][1]); end
         end
      end
   endtask

   task automatic test_gaps();
      logic [7:0] ref_q [$];
      seq.delete();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < LW; c++) begin
            push(pat(3, r, c), r == 0 && c == 0);
            checks++;
            if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
               errors++;
               $display("FAIL ramp r%0d c%0d got v=%b h=%h exp v=%b h=%h", r, c, obs_v, obs_h, exp_v, exp_h);
            end
         end
      ref_q = seq;
      seq.delete();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < LW; c++) begin
            push(pat(3, r, c), r == 0 && c == 0);
            checks++;
            if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
               errors++;
               $display("FAIL gap_push r%0d c%0d got v=%b h=%h exp v=%b h=%h", r, c, obs_v, obs_h, exp_v, exp_h);
            end
            gap();
            checks++;
            if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
               errors++;
               $display("FAIL gap_idle r%0d c%0d got v=%b h=%h exp v=%b h=%h", r, c, obs_v, obs_h, exp_v, exp_h);
            end
         end
      checks++;
      if (seq.size() != ref_q.size() || seq != ref_q) begin
         errors++;
         $display("FAIL gap_sequence got %0d vectors exp %0d identical", seq.size(), ref_q.size());
      end
   endtask

   task automatic test_sof_mid();
      for (int i = 0; i < 3 * LW + 7; i++) begin
         push(pat(4, 0, 0), i == 0);
         checks++;
         if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
            errors++;
            $display("FAIL sof_pre i%0d got v=%b h=%h exp v=%b h=%h", i, obs_v, obs_h, exp_v, exp_h);
         end
      end
      pulses = 0;
      for (int i = 0; i < 5 * LW; i++) begin
         push(pat(4, 0, 0), i == 0);
         checks++;
         if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
            errors++;
            $display("FAIL sof_new i%0d got v=%b h=%h exp v=%b h=%h", i, obs_v, obs_h, exp_v, exp_h);
         end
      end
      checks++;
      if (pulses != 42) begin errors++; $display("FAIL sof_pulses got %0d exp 42", pulses); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3 * LW + 5; i++) begin
         push(pat(4, 0, 0), i == 0);
         checks++;
         if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
            errors++;
            $display("FAIL rst_pre i%0d got v=%b h=%h exp v=%b h=%h", i, obs_v, obs_h, exp_v, exp_h);
         end
      end
      reset = 1'b0; pix_valid = 1'b1; sof = 1'b0; pix_in = 8'h33;
      @(posedge clk); #1;
      reset = 1'b1; pix_valid = 1'b0;
      checks++;
      if ({ham_valid, ham_out} !== 9'h000) begin
         errors++;
         $display("FAIL rst_mid got v=%b h=%h exp v=0 h=00", ham_valid, ham_out);
      end
      model_reset();
      pulses = 0;
      for (int i = 0; i < 5 * LW; i++) begin
         push(pat(4, 0, 0), 1'b0);
         checks++;
         if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
            errors++;
            $display("FAIL rst_post i%0d got v=%b h=%h exp v=%b h=%h", i, obs_v, obs_h, exp_v, exp_h);
         end
      end
      checks++;
      if (pulses != 42) begin errors++; $display("FAIL rst_pulses got %0d exp 42", pulses); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 3; f++) begin
         int lines;
         lines  = $urandom_range(3, 7);
         pulses = 0;
         for (int i = 0; i < lines * LW; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               gap();
               checks++;
               if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
                  errors++;
                  $display("FAIL rand_gap f%0d i%0d got v=%b h=%h exp v=%b h=%h", f, i, obs_v, obs_h, exp_v, exp_h);
               end
            end
            push(8'($urandom_range(0, 7) * 32), i == 0);
            checks++;
            if ({obs_v, obs_h} !== {exp_v, exp_h}) begin
               errors++;
               $display("FAIL rand_px f%0d i%0d got v=%b h=%h exp v=%b h=%h", f, i, obs_v, obs_h, exp_v, exp_h);
            end
         end
         checks++;
         if (pulses != (lines - 2) * (LW - 2)) begin
            errors++;
            $display("FAIL rand_pulses f%0d got %0d exp %0d", f, pulses, (lines - 2) * (LW - 2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_images();
      test_gaps();
      test_sof_mid();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
